fib_seq_gen: RTL and testbench

Parametrised two-term recurrence generator, the successor to the fixed 8-bit single-step generator.
- Holds an (a, b) pair and, on command, steps (a, b) -> (b, a+b mod 2^WIDTH).
- Adds load, hold, multi-step RUN with abort, and a valid/ready output stage with backpressure.
- Sits between a command source (sequencer/testbench driver) and a downstream consumer of the sequence.

---
 rtl/fib_seq_pkg.sv | 16 +
 rtl/fib_seq_gen_if.sv | 32 +++
 rtl/fib_step.sv | 19 +
 rtl/fib_seq_gen.sv | 131 +++++++++++++
 tb/tb_fib_seq_gen.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_seq_pkg.sv
// rtl/fib_seq_pkg.sv - shared command and state types for the recurrence generator
package fib_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_RUN  = 2'd3
  } cmd_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fib_seq_gen_if.sv
// rtl/fib_seq_gen_if.sv - command and result handshake bundle of the recurrence generator
interface fib_seq_gen_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) ();
  import fib_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_arg_a;
  logic [WIDTH-1:0] cmd_arg_b;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_wrap;
  logic             busy;
  logic [CNT_W-1:0] remaining;

  modport master (
    output cmd_valid, cmd_op, cmd_arg_a, cmd_arg_b, cmd_count, abort, out_ready,
    input  cmd_ready, out_valid, out_data, out_wrap, busy, remaining
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg_a, cmd_arg_b, cmd_count, abort, out_ready,
    output cmd_ready, out_valid, out_data, out_wrap, busy, remaining
  );

endinterface

// File: rtl/fib_step.sv
// rtl/fib_step.sv - one (a, b) -> (b, a+b) recurrence step with carry-out
module fib_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_next_o,
  output logic [WIDTH-1:0] b_next_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum;

  assign sum      = {1'b0, a_i} + {1'b0, b_i};
  assign a_next_o = b_i;
  assign b_next_o = sum[WIDTH-1:0];
  assign carry_o  = sum[WIDTH];

endmodule

// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - two-term recurrence generator with load/hold/run commands and a backpressured result slot
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      CNT_W  = 8,
  parameter logic [WIDTH-1:0] SEED_A = '0,
  parameter logic [WIDTH-1:0] SEED_B = WIDTH'(1)
) (
  input  logic         clk,
  input  logic         rst,
  fib_seq_gen_if.slave bus
);

  typedef struct packed {
    logic             wrap;
    logic [WIDTH-1:0] data;
  } result_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  result_t          res_q, res_d;

  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic             carry;
  logic             slot_free;
  logic             cmd_fire;
  logic             do_step;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .a_next_o (a_nx),
    .b_next_o (b_nx),
    .carry_o  (carry)
  );

  assign slot_free = !out_valid_q || bus.out_ready;
  assign cmd_fire  = bus.cmd_valid && (state_q == S_IDLE) && slot_free;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    res_d       = res_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    do_step     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          unique case (bus.cmd_op)
            OP_HOLD: begin
              out_valid_d = 1'b1;
              res_d.wrap  = 1'b0;
              res_d.data  = a_q;
            end
            OP_STEP: do_step = 1'b1;
            OP_LOAD: begin
              a_d         = bus.cmd_arg_a;
              b_d         = bus.cmd_arg_b;
              out_valid_d = 1'b1;
              res_d.wrap  = 1'b0;
              res_d.data  = bus.cmd_arg_a;
            end
            OP_RUN: begin
              // A zero-length run is consumed silently and leaves the FSM idle.
              if (bus.cmd_count != '0) begin
                do_step = 1'b1;
                rem_d   = bus.cmd_count - CNT_W'(1);
                state_d = S_RUN;
              end
            end
          endcase
        end
      end
      S_RUN: begin
        if (rem_q == '0) begin
          state_d = S_IDLE;
        end else if (slot_free) begin
          do_step = 1'b1;
          rem_d   = rem_q - CNT_W'(1);
        end
        // The step issued alongside abort still lands in the result slot.
        if (bus.abort) begin
          rem_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase

    if (do_step) begin
      a_d         = a_nx;
      b_d         = b_nx;
      out_valid_d = 1'b1;
      res_d.wrap  = carry;
      res_d.data  = b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= SEED_A;
      b_q         <= SEED_B;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE) && slot_free;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_q.data;
  assign bus.out_wrap  = res_q.wrap;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb/tb_fib_seq_gen.sv - scoreboard bench for fib_seq_gen
module tb_fib_seq_gen;
  import fib_seq_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic             wrap;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fib_seq_gen #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .SEED_A (8'd0),
    .SEED_B (8'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH-1:0] fib_tab [13] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                                     8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HOLD;
    bus.cmd_arg_a = '0;
    bus.cmd_arg_b = '0;
    bus.cmd_count = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic model_reset();
    ma = 8'd0;
    mb = 8'd1;
    sb.delete();
  endtask

  task automatic model_step();
    logic [WIDTH:0] s;
    s = {1'b0, ma} + {1'b0, mb};
    sb.push_back('{wrap: s[WIDTH], data: mb});
    ma = mb;
    mb = s[WIDTH-1:0];
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_STEP;
    tick();
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got out_valid=%0b busy=%0b, expected 0 0", bus.out_valid, bus.busy);
    end
    vectors++;
    if (bus.out_data !== 8'd0 || bus.out_wrap !== 1'b0 || bus.remaining !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_values: got data=%0d wrap=%0b remaining=%0d, expected 0 0 0",
               bus.out_data, bus.out_wrap, bus.remaining);
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_cmd_ready: got %0b, expected 1", bus.cmd_ready);
    end
    tick();
  endtask

  task automatic test_step();
    int   n_out = 0;
    logic acc_prev = 1'b0;
    exp_t e, got;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.cmd_valid = (c < 5);
      bus.cmd_op    = OP_STEP;
      @(negedge clk);
      if (acc_prev) begin
        vectors++;
        if (bus.out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL step_latency: cycle %0d out_valid=%0b, expected 1", c, bus.out_valid);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got.wrap = bus.out_wrap;
        got.data = bus.out_data;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL step_extra: got data=%0d, expected no output", got.data);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL step_sb: got wrap=%0b data=%0d, expected wrap=%0b data=%0d",
                     got.wrap, got.data, e.wrap, e.data);
          end
        end
        vectors++;
        if (n_out >= 13 || got.data !== fib_tab[n_out] || got.wrap !== 1'b0) begin
          miscompares++;
          $display("FAIL step_table: output %0d got data=%0d wrap=%0b", n_out, got.data, got.wrap);
        end
        n_out++;
      end
      acc_prev = bus.cmd_valid && bus.cmd_ready;
      if (acc_prev) model_step();
      tick();
    end
    bus.cmd_valid = 1'b0;
    vectors++;
    if (n_out !== 5 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL step_count: got %0d outputs (%0d pending), expected 5 (0)", n_out, sb.size());
    end
  endtask

  task automatic test_run13();
    int   n_out = 0;
    logic was_busy = 1'b0;
    logic fell = 1'b0;
    exp_t e, got;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.cmd_valid = (c == 0);
      bus.cmd_op    = OP_RUN;
      bus.cmd_count = 8'd13;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got.wrap = bus.out_wrap;
        got.data = bus.out_data;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL run13_extra: got data=%0d, expected no output", got.data);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL run13_sb: got wrap=%0b data=%0d, expected wrap=%0b data=%0d",
                     got.wrap, got.data, e.wrap, e.data);
          end
        end
        vectors++;
        if (n_out >= 13 || got.data !== fib_tab[n_out] || got.wrap !== (n_out == 12)) begin
          miscompares++;
          $display("FAIL run13_table: output %0d got data=%0d wrap=%0b", n_out, got.data, got.wrap);
        end
        n_out++;
      end
      if (was_busy && !bus.busy && !fell) begin
        fell = 1'b1;
        vectors++;
        if (n_out !== 13) begin
          miscompares++;
          $display("FAIL run13_busy_fall: busy fell after %0d outputs, expected 13", n_out);
        end
      end
      was_busy = bus.busy;
      if (bus.cmd_valid && bus.cmd_ready) repeat (13) model_step();
      tick();
    end
    bus.cmd_valid = 1'b0;
    vectors++;
    if (n_out !== 13 || !fell || bus.remaining !== 8'd0 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL run13_end: got outputs=%0d busy_fell=%0b remaining=%0d pending=%0d, expected 13 1 0 0",
               n_out, fell, bus.remaining, sb.size());
    end
  endtask

  task automatic test_stall();
    int   n_out = 0;
    exp_t e, got;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.cmd_valid = (c == 0);
      bus.cmd_op    = OP_RUN;
      bus.cmd_count = 8'd4;
      bus.out_ready = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd1 || bus.remaining !== 8'd3) begin
          miscompares++;
          $display("FAIL stall_hold: cycle %0d got valid=%0b data=%0d remaining=%0d, expected 1 1 3",
                   c, bus.out_valid, bus.out_data, bus.remaining);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got.wrap = bus.out_wrap;
        got.data = bus.out_data;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL stall_extra: got data=%0d, expected no output", got.data);
        end else begin
          e = sb.pop_front();
          if (got !== e || got.data !== fib_tab[n_out % 13]) begin
            miscompares++;
            $display("FAIL stall_sb: got wrap=%0b data=%0d, expected wrap=%0b data=%0d",
                     got.wrap, got.data, e.wrap, e.data);
          end
        end
        n_out++;
      end
      if (bus.cmd_valid && bus.cmd_ready) repeat (4) model_step();
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    vectors++;
    if (n_out !== 4 || bus.remaining !== 8'd0 || bus.busy !== 1'b0 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL stall_end: got outputs=%0d remaining=%0d busy=%0b pending=%0d, expected 4 0 0 0",
               n_out, bus.remaining, bus.busy, sb.size());
    end
  endtask

  task automatic test_load();
    cmd_op_e          lops  [4] = '{OP_LOAD, OP_STEP, OP_HOLD, OP_STEP};
    logic [WIDTH-1:0] ldata [4] = '{8'd200, 8'd100, 8'd100, 8'd44};
    logic             lwrap [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int   ci = 0;
    int   n_out = 0;
    exp_t e, got;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.cmd_valid = (ci < 4);
      bus.cmd_op    = (ci < 4) ? lops[ci] : OP_HOLD;
      bus.cmd_arg_a = 8'd200;
      bus.cmd_arg_b = 8'd100;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got.wrap = bus.out_wrap;
        got.data = bus.out_data;
        vectors++;
        if (sb.size() == 0 || n_out >= 4) begin
          miscompares++;
          $display("FAIL load_extra: got data=%0d, expected no output", got.data);
        end else begin
          e = sb.pop_front();
          if (got !== e || got.data !== ldata[n_out] || got.wrap !== lwrap[n_out]) begin
            miscompares++;
            $display("FAIL load_seq: output %0d got wrap=%0b data=%0d, expected wrap=%0b data=%0d",
                     n_out, got.wrap, got.data, lwrap[n_out], ldata[n_out]);
          end
        end
        n_out++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        case (bus.cmd_op)
          OP_LOAD: begin
            sb.push_back('{wrap: 1'b0, data: bus.cmd_arg_a});
            ma = bus.cmd_arg_a;
            mb = bus.cmd_arg_b;
          end
          OP_HOLD: sb.push_back('{wrap: 1'b0, data: ma});
          default: model_step();
        endcase
        ci++;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    vectors++;
    if (n_out !== 4 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL load_count: got %0d outputs (%0d pending), expected 4 (0)", n_out, sb.size());
    end
  endtask

  task automatic test_abort();
    int   n_out = 0;
    exp_t e, got;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bus.cmd_valid = (c == 0) || (c == 5);
      bus.cmd_op    = (c == 0) ? OP_RUN : OP_HOLD;
      bus.cmd_count = 8'd10;
      bus.abort     = (c == 2);
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if (bus.busy !== 1'b0 || bus.remaining !== 8'd0 || bus.cmd_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL abort_idle: got busy=%0b remaining=%0d cmd_ready=%0b, expected 0 0 1",
                   bus.busy, bus.remaining, bus.cmd_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got.wrap = bus.out_wrap;
        got.data = bus.out_data;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL abort_extra: got data=%0d, expected no output", got.data);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL abort_sb: got wrap=%0b data=%0d, expected wrap=%0b data=%0d",
                     got.wrap, got.data, e.wrap, e.data);
          end
        end
        vectors++;
        if ((n_out < 3 && got.data !== fib_tab[n_out]) || (n_out == 3 && got.data !== 8'd2)) begin
          miscompares++;
          $display("FAIL abort_seq: output %0d got data=%0d", n_out, got.data);
        end
        n_out++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (bus.cmd_op == OP_RUN) repeat (3) model_step();
        else sb.push_back('{wrap: 1'b0, data: ma});
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    vectors++;
    if (n_out !== 4 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL abort_count: got %0d outputs (%0d pending), expected 4 (0)", n_out, sb.size());
    end
  endtask

  task automatic test_rst_mid_run();
    int   n_out = 0;
    exp_t e, got;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bus.cmd_valid = (c == 0) || (c == 5) || (c == 7);
      bus.cmd_op    = (c == 5) ? OP_HOLD : OP_RUN;
      bus.cmd_count = (c == 0) ? 8'd10 : 8'd0;
      bus.out_ready = (c != 3);
      rst           = (c == 3);
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || n_out !== 2) begin
          miscompares++;
          $display("FAIL rst_precond: got out_valid=%0b outputs=%0d, expected 1 2", bus.out_valid, n_out);
        end
      end
      if (c == 4) begin
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.remaining !== 8'd0) begin
          miscompares++;
          $display("FAIL rst_mid_run: got out_valid=%0b busy=%0b remaining=%0d, expected 0 0 0",
                   bus.out_valid, bus.busy, bus.remaining);
        end
        model_reset();
      end
      if (c >= 8) begin
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL run_zero: cycle %0d got out_valid=%0b cmd_ready=%0b busy=%0b, expected 0 1 0",
                   c, bus.out_valid, bus.cmd_ready, bus.busy);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got.wrap = bus.out_wrap;
        got.data = bus.out_data;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rst_extra: got data=%0d, expected no output", got.data);
        end else begin
          e = sb.pop_front();
          if (got !== e || (n_out == 2 && got.data !== 8'd0)) begin
            miscompares++;
            $display("FAIL rst_sb: output %0d got wrap=%0b data=%0d, expected wrap=%0b data=%0d",
                     n_out, got.wrap, got.data, e.wrap, e.data);
          end
        end
        n_out++;
      end
      if (bus.cmd_valid && bus.cmd_ready && !rst) begin
        if (bus.cmd_op == OP_HOLD) sb.push_back('{wrap: 1'b0, data: ma});
        else repeat (int'(bus.cmd_count)) model_step();
      end
      tick();
    end
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    vectors++;
    if (n_out !== 3 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL rst_count: got %0d outputs (%0d pending), expected 3 (0)", n_out, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_step();
    test_run13();
    test_stall();
    test_load();
    test_abort();
    test_rst_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
